// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encodings, FSM states, iteration count, corner-case constants
// and small helpers used by both the sequencer and the iteration step.
package md_sequencer_pkg;

  localparam int XLEN    = 32;
  localparam int MD_ITER = XLEN;

  localparam logic [5:0] MD_LAST_ITER = 6'(MD_ITER - 1);

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MD_OVF_VAL  = 32'h8000_0000;
  localparam logic [XLEN-1:0] MD_ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } md_state_t;

  // Operand signedness {src_a signed, src_b signed}. MUL only needs the low
  // half, which is the same for any signedness, so it runs unsigned.
  function automatic logic [1:0] md_key(input logic [2:0] op);
    case (op)
      MD_MULH:   md_key = 2'b11;
      MD_MULHSU: md_key = 2'b10;
      MD_DIV:    md_key = 2'b11;
      MD_REM:    md_key = 2'b11;
      default:   md_key = 2'b00;
    endcase
  endfunction

  // Two's-complement negate when neg is set.
  function automatic logic [XLEN-1:0] md_cneg(input logic [XLEN-1:0] v, input logic neg);
    md_cneg = neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Pick the architectural result: lo holds product-low / quotient,
  // hi holds product-high / remainder.
  function automatic logic [XLEN-1:0] md_select(input logic [2:0] op,
                                                input logic [XLEN-1:0] hi,
                                                input logic [XLEN-1:0] lo);
    md_select = ((op == MD_MUL) || (op == MD_DIV) || (op == MD_DIVU)) ? lo : hi;
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// One combinational iteration of the multiply/divide datapath.
// mode=0: shift-add multiply step on {hi,lo} (lo holds the multiplier).
// mode=1: restoring divide step; hi is the partial remainder, lo shifts
// the dividend out and the quotient bits in.
module md_iter_step
  import md_sequencer_pkg::*;
(
  input  logic            mode,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Compute the next {hi,lo} for the selected operation.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, operand};
    if (mode) begin
      // The partial remainder is below the divisor, so bit XLEN of diff
      // is set exactly when the trial subtraction borrows.
      if (!diff[XLEN]) begin
        hi_next = diff[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_next = shifted[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Iterative RV32M multiply/divide unit for the EX stage. Holds the pipeline
// via stall_o for 34 cycles per operation and strobes done for one cycle
// with the result. Divide-by-zero and signed overflow finish in one cycle.
// Optional result cache enabled by defining MD_OPCACHE_EN.
module md_sequencer
  import md_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            stall_o,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_t       state;
  logic [5:0]      cnt;
  logic [2:0]      op_r;
  logic [XLEN-1:0] hi_r, lo_r, operand_r;
  logic            neg_main_r, neg_rem_r;
  logic [XLEN-1:0] result_r;
  logic            done_r;

  logic            is_div, a_neg, b_neg, div_zero, div_ovf, accept;
  logic [1:0]      key;
  logic [XLEN-1:0] abs_a, abs_b, fast_quo, fast_rem;
  logic [XLEN-1:0] step_hi, step_lo, fix_hi, fix_lo;
  logic [2*XLEN-1:0] prod;
  logic            cache_hit;
  logic [XLEN-1:0] cache_res;

  assign accept  = (state == S_IDLE) && start && !flush;
  assign stall_o = accept || (state == S_CALC) || (state == S_FIX);
  assign busy    = (state != S_IDLE);
  assign done    = done_r;
  assign result  = result_r;

  // Decode the incoming operation: signs, magnitudes and divide corner cases.
  always_comb begin
    is_div   = op[2];
    key      = md_key(op);
    a_neg    = key[1] && src_a[XLEN-1];
    b_neg    = key[0] && src_b[XLEN-1];
    abs_a    = md_cneg(src_a, a_neg);
    abs_b    = md_cneg(src_b, b_neg);
    div_zero = is_div && (src_b == {XLEN{1'b0}});
    div_ovf  = ((op == MD_DIV) || (op == MD_REM)) &&
               (src_a == MD_OVF_VAL) && (src_b == MD_ALL_ONES);
    if (div_zero) begin
      fast_quo = MD_ALL_ONES;
      fast_rem = src_a;
    end else begin
      fast_quo = MD_OVF_VAL;
      fast_rem = {XLEN{1'b0}};
    end
  end

  md_iter_step u_step (
    .mode    (op_r[2]),
    .hi      (hi_r),
    .lo      (lo_r),
    .operand (operand_r),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  // Sign correction of the finished magnitude result.
  always_comb begin
    prod = {hi_r, lo_r};
    if (op_r[2]) begin
      fix_lo = md_cneg(lo_r, neg_main_r);
      fix_hi = md_cneg(hi_r, neg_rem_r);
    end else begin
      if (neg_main_r) begin
        prod = ~prod + {{(2*XLEN-1){1'b0}}, 1'b1};
      end else begin
        prod = {hi_r, lo_r};
      end
      fix_hi = prod[2*XLEN-1:XLEN];
      fix_lo = prod[XLEN-1:0];
    end
  end

`ifdef MD_OPCACHE_EN
  logic            c_valid, c_div;
  logic [1:0]      c_key;
  logic [XLEN-1:0] c_a, c_b, c_hi, c_lo, p_a, p_b;

  // A MUL can reuse any cached product; other ops need matching signedness
  // because the high half and the quotient depend on it.
  assign cache_hit = c_valid && (src_a == c_a) && (src_b == c_b) && (c_div == is_div) &&
                     ((op == MD_MUL) || (c_key == key));
  assign cache_res = md_select(op, c_hi, c_lo);

  // Remember the last completed operation; flush or reset invalidates it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_valid <= 1'b0;
      c_div   <= 1'b0;
      c_key   <= 2'b00;
      c_a     <= {XLEN{1'b0}};
      c_b     <= {XLEN{1'b0}};
      c_hi    <= {XLEN{1'b0}};
      c_lo    <= {XLEN{1'b0}};
      p_a     <= {XLEN{1'b0}};
      p_b     <= {XLEN{1'b0}};
    end else if (flush) begin
      c_valid <= 1'b0;
    end else if (accept && (div_zero || div_ovf)) begin
      c_valid <= 1'b1;
      c_div   <= 1'b1;
      c_key   <= key;
      c_a     <= src_a;
      c_b     <= src_b;
      c_hi    <= fast_rem;
      c_lo    <= fast_quo;
    end else if (accept && !cache_hit) begin
      p_a <= src_a;
      p_b <= src_b;
    end else if (state == S_FIX) begin
      c_valid <= 1'b1;
      c_div   <= op_r[2];
      c_key   <= md_key(op_r);
      c_a     <= p_a;
      c_b     <= p_b;
      c_hi    <= fix_hi;
      c_lo    <= fix_lo;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = {XLEN{1'b0}};
`endif

  // Sequencer FSM with iteration counter and registered result/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 6'd0;
      op_r       <= 3'b000;
      hi_r       <= {XLEN{1'b0}};
      lo_r       <= {XLEN{1'b0}};
      operand_r  <= {XLEN{1'b0}};
      neg_main_r <= 1'b0;
      neg_rem_r  <= 1'b0;
      result_r   <= {XLEN{1'b0}};
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              op_r <= op;
              cnt  <= 6'd0;
              if (div_zero || div_ovf) begin
                state    <= S_DONE;
                done_r   <= 1'b1;
                result_r <= md_select(op, fast_rem, fast_quo);
              end else if (cache_hit) begin
                state    <= S_DONE;
                done_r   <= 1'b1;
                result_r <= cache_res;
              end else begin
                state      <= S_CALC;
                hi_r       <= {XLEN{1'b0}};
                lo_r       <= is_div ? abs_a : abs_b;
                operand_r  <= is_div ? abs_b : abs_a;
                neg_main_r <= a_neg ^ b_neg;
                neg_rem_r  <= a_neg;
              end
            end
          end
          S_CALC: begin
            hi_r <= step_hi;
            lo_r <= step_lo;
            cnt  <= cnt + 6'd1;
            if (cnt == MD_LAST_ITER) begin
              state <= S_FIX;
            end
          end
          S_FIX: begin
            hi_r     <= fix_hi;
            lo_r     <= fix_lo;
            result_r <= md_select(op_r, fix_hi, fix_lo);
            done_r   <= 1'b1;
            state    <= S_DONE;
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed cases plus randomized
// operations compared against an arithmetic reference model. Define
// MD_OPCACHE_EN for both bench and RTL to exercise the result cache.
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] src_a, src_b, result;
  logic        stall_o, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  md_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .flush   (flush),
    .stall_o (stall_o),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Arithmetic reference using 64-bit integer math.
  function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Cache model: the last completed operands, class and signedness.
  bit          m_valid = 1'b0;
  bit          m_div;
  bit [1:0]    m_sig;
  logic [31:0] m_a, m_b;

  function automatic bit [1:0] sig_of(input logic [2:0] o);
    if (o == 3'd1 || o == 3'd4 || o == 3'd6) return 2'b11;
    if (o == 3'd2) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit is_corner(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && (b == 32'd0 ||
           ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic bit cache_hit(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MD_OPCACHE_EN
    return m_valid && a == m_a && b == m_b && m_div == o[2] && (o == 3'd0 || m_sig == sig_of(o));
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit hold);
    int lat, stall_cnt;
    bit seen, hit;
    logic [31:0] exp;
    exp = ref_md(o, a, b);
    hit = cache_hit(o, a, b);
    lat = (is_corner(o, a, b) || hit) ? 1 : 34;
    @(posedge clk); #1;
    op = o; src_a = a; src_b = b; start = 1'b1;
    #1;
    stall_cnt = stall_o ? 1 : 0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      #1;
      if (done) begin
        seen = 1'b1;
        start = 1'b0;
        check($sformatf("latency op%0d", o), k, lat);
        check($sformatf("result op%0d a=%08h b=%08h", o, a, b), result, exp);
      end else if (stall_o) begin
        stall_cnt++;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    check("stall_cycles", stall_cnt, (lat == 34) ? 34 : 1);
    @(posedge clk); #2;
    check("done_single", {31'd0, done}, 32'd0);
    check("idle_after", {31'd0, busy}, 32'd0);
    if (seen && !hit) begin
      m_valid = 1'b1; m_a = a; m_b = b; m_div = o[2]; m_sig = sig_of(o);
    end
  endtask

  logic [31:0] prev, la, lb, ra, rb;
  logic [2:0]  ro;
  int          sel;

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    #12;
    check("rst_result", result, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk) rst = 1'b0;

    run_op(MD_MUL, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(MD_REM, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(MD_DIVU, 32'd100, 32'd7, 1'b0);
    run_op(MD_REMU, 32'd100, 32'd7, 1'b0);
    run_op(MD_DIVU, 32'd5, 32'd0, 1'b0);
    run_op(MD_REM, 32'd5, 32'd0, 1'b0);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(MD_DIV, 32'd100, 32'd7, 1'b0);
    run_op(MD_REM, 32'd100, 32'd7, 1'b0);

    // flush and start together: start must be ignored
    @(posedge clk); #1;
    op = MD_DIVU; src_a = 32'd1000; src_b = 32'd3; start = 1'b1; flush = 1'b1;
    #1;
    check("flush_start_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; m_valid = 1'b0;
    #1;
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    check("flush_start_done", {31'd0, done}, 32'd0);

    // flush in the 10th CALC cycle
    prev = result;
    @(posedge clk); #1;
    op = MD_DIVU; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("calc_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; m_valid = 1'b0;
    #1;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_result", result, prev);
    @(posedge clk); #2;
    check("flush_done_later", {31'd0, done}, 32'd0);
    run_op(MD_DIVU, 32'd1000, 32'd3, 1'b0);

    // start held high across the whole operation
    run_op(MD_REMU, 32'd12345, 32'd100, 1'b1);
    repeat (3) begin
      @(posedge clk); #2;
      check("hold_no_second_done", {31'd0, done}, 32'd0);
    end

    // reset in the middle of CALC
    @(posedge clk); #1;
    op = MD_MUL; src_a = 32'd12345; src_b = 32'd678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_result", result, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_stall", {31'd0, stall_o}, 32'd0);
    m_valid = 1'b0;
    @(negedge clk) rst = 1'b0;

    // randomized operations, biased towards corners and operand reuse
    la = 32'd1; lb = 32'd1;
    for (int i = 0; i < 60; i++) begin
      ro  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel <= 3) begin ra = la; rb = lb; end
      else if (sel == 4) rb = 32'($urandom_range(1, 15));
      run_op(ro, ra, rb, 1'b0);
      la = ra; lb = rb;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its own sequencer, sitting beside the ALU in the EX stage.
- Accepts one M-extension operation from EX and holds the pipeline through its stall output until the result is ready.
- On completion it presents the result for one cycle so the EX-stage result mux can forward it to EX/MEM.
- Honours pipeline flush and supports a single-cycle fast path for divide corner cases.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  M-type instruction valid in EX (level; sampled only in IDLE)
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- src_a  in  XLEN  forwarded rs1 value
- src_b  in  XLEN  forwarded rs2 value
- flush  in  1  kill in-flight operation (branch/jalr mispredict)
- stall_o  out  1  pipeline hold request, ORed into PL_stall by EX
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle result-valid strobe
- result  out  XLEN  operation result

Behaviour:
- Reset (async, rst=1): state=IDLE; result=0, done=0, busy=0. stall_o follows its combinational rule (0 while start=0). Reset mid-operation aborts with no done.
- States: IDLE, CALC, FIX, DONE.
- Normal flow, with start seen in IDLE in cycle T:
  - T: latch op, |a|, |b| and sign flags; stall_o=1 combinationally from start.
  - IDLE->CALC.
  - T+1..T+32: CALC, one iteration per cycle; a 6-bit counter runs 0..31.
  - T+33: FIX, one cycle of sign correction.
  - T+34: DONE; done=1, result valid, stall_o=0, then ->IDLE.
- stall_o = (IDLE & start & !flush) | CALC | FIX. Total hold is 34 cycles.
- Multiply:
  - Unsigned shift-add on magnitudes produces a 2*XLEN product.
  - Operands treated as signed: MULH both, MULHSU src_a only.
  - FIX negates the product when the operand signs differ.
  - MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
- Divide:
  - Restoring division on magnitudes (signed for DIV/REM).
  - FIX negates the quotient when the signs differ; the remainder takes the dividend's sign.
- Fast path, IDLE->DONE directly, done at T+1:
  - Divide by zero: quotient=all ones, remainder=src_a.
  - Signed overflow (DIV/REM, src_a=0x80000000, src_b=0xFFFFFFFF): quotient=0x80000000, remainder=0.
- flush in any state: next state IDLE; done is not raised for the killed op; result is unchanged.
- flush and start in the same cycle: start is ignored.
- start while not IDLE: ignored; the operation in flight continues.
- result holds its last value until the next DONE. done is never high two consecutive cycles.

Optional Feature:
- MD_OPCACHE_EN defined:
  - Keeps the last completed src_a, src_b, op-class (mul or div) and the full 2*XLEN product, or quotient plus remainder, with a valid bit.
  - A start in IDLE whose operands and op-class match the cached entry goes IDLE->DONE; done at T+1, stall_o high only in cycle T.
  - Typical hits: MULH then MUL, or DIV then REM, on the same operands.
  - The valid bit is cleared by rst and by flush.
- MD_OPCACHE_EN undefined: no cache registers; every non-corner operation takes 34 cycles.

Decomposition:
- Shared package/define file:
  - op encodings: MD_MUL..MD_REMU.
  - FSM state encodings.
  - MD_ITER = XLEN.
  - Overflow and divide-by-zero constants: 0x80000000, 0xFFFFFFFF.
- One sub-module, md_iter_step: combinational single iteration.
  - Shift-add step for mul, restore-subtract step for div, selected by a mode bit.
  - Instantiated once in md_sequencer, which keeps the FSM, counter, sign handling and registers.

Test Plan:
- MUL src_a=7, src_b=0xFFFFFFFD -> result=0xFFFFFFEB; done exactly 34 cycles after start; stall_o high 34 cycles.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF, and REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; each with done at T+1.
- flush in the 10th CALC cycle -> IDLE next cycle, no done, result keeps its old value. A new start 2 cycles later completes normally.
- rst asserted mid-CALC -> outputs 0 immediately. start held high while busy -> only one done.
- With MD_OPCACHE_EN, DIV 100/7 then REM 100/7 -> REM returns 2 with done at T+1.
